dbu_run_ctrl: RTL and testbench

- CPU-side counterpart of the debug unit (DBU).
- Takes the operator controls (succ, step, inc, dec, m_rf) and turns them into a CPU clock enable, a memory/register-file inspection address, and an executed-cycle count.
- Scans the 32-bit inspected word onto an 8-digit multiplexed 7-segment display.
- Sits between board I/O and the single-cycle CPU's debug ports.

---
 rtl/dbu_run_ctrl.sv | 271 +++++++++++++++++++++++++++
 tb/tb_dbu_run_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/dbu_run_ctrl.sv
// dbu_run_ctrl: run/step control, inspection address and 7-segment scan
// for the CPU side of the debug unit. Raw board inputs are synchronized,
// buttons are debounced into single-cycle pulses, a small FSM produces the
// CPU clock enable, and the inspected word is shown on eight hex digits.
module dbu_run_ctrl #(
  parameter int DEB_CYCLES = 4,
  parameter int SCAN_DIV   = 16,
  parameter int ADDR_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              succ,
  input  logic              step,
  input  logic              inc,
  input  logic              dec,
  input  logic              m_rf,
  input  logic [31:0]       cpu_data,
  output logic              cpu_en,
  output logic [ADDR_W-1:0] m_rf_addr,
  output logic [15:0]       cycles,
  output logic [7:0]        an,
  output logic [6:0]        seg
);

  localparam int DEB_W  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;
  localparam int SCAN_W = $clog2(SCAN_DIV + 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } state_t;

  // Active-low hex glyph, segment order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0:    g = 7'h40;
      4'h1:    g = 7'h79;
      4'h2:    g = 7'h24;
      4'h3:    g = 7'h30;
      4'h4:    g = 7'h19;
      4'h5:    g = 7'h12;
      4'h6:    g = 7'h02;
      4'h7:    g = 7'h78;
      4'h8:    g = 7'h00;
      4'h9:    g = 7'h10;
      4'hA:    g = 7'h08;
      4'hB:    g = 7'h03;
      4'hC:    g = 7'h46;
      4'hD:    g = 7'h21;
      4'hE:    g = 7'h06;
      4'hF:    g = 7'h0E;
      default: g = 7'h7F;
    endcase
    return g;
  endfunction

  // ---------------- input synchronizers ----------------
  // bit order: [0] step, [1] inc, [2] dec, [3] succ, [4] m_rf
  logic [4:0] sync1_q, sync2_q;
  logic [2:0] btn_s;
  logic       succ_s;
  logic       m_rf_s;

  assign btn_s  = sync2_q[2:0];
  assign succ_s = sync2_q[3];
  assign m_rf_s = sync2_q[4];

  // Two-stage synchronizer for every asynchronous board input.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 5'd0;
      sync2_q <= 5'd0;
    end else begin
      sync1_q <= {m_rf, succ, dec, inc, step};
      sync2_q <= sync1_q;
    end
  end

  // ---------------- button debouncers ----------------
  logic [2:0]       btn_lvl_q, btn_lvl_d;
  logic [2:0]       btn_prev_q;
  logic [2:0]       btn_p_q;
  logic [DEB_W-1:0] btn_cnt_q [3];
  logic [DEB_W-1:0] btn_cnt_d [3];

  // Level follows the synchronized input only after DEB_CYCLES consecutive mismatching cycles.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      btn_lvl_d[i] = btn_lvl_q[i];
      btn_cnt_d[i] = '0;
      if (btn_s[i] != btn_lvl_q[i]) begin
        if (btn_cnt_q[i] == DEB_LAST) begin
          btn_lvl_d[i] = btn_s[i];
          btn_cnt_d[i] = '0;
        end else begin
          btn_cnt_d[i] = btn_cnt_q[i] + DEB_W'(1);
        end
      end else begin
        btn_cnt_d[i] = '0;
      end
    end
  end

  // Debounce state plus registered rising-edge pulses of the debounced levels.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_lvl_q  <= 3'd0;
      btn_prev_q <= 3'd0;
      btn_p_q    <= 3'd0;
      for (int i = 0; i < 3; i++) begin
        btn_cnt_q[i] <= '0;
      end
    end else begin
      btn_lvl_q  <= btn_lvl_d;
      btn_prev_q <= btn_lvl_q;
      btn_p_q    <= btn_lvl_q & ~btn_prev_q;
      for (int i = 0; i < 3; i++) begin
        btn_cnt_q[i] <= btn_cnt_d[i];
      end
    end
  end

  logic step_p, inc_p, dec_p;
  assign step_p = btn_p_q[0];
  assign inc_p  = btn_p_q[1];
  assign dec_p  = btn_p_q[2];

  // ---------------- run FSM ----------------
  state_t state_q, state_d;
  logic   cpu_en_q, cpu_en_d;

  // Next state; cpu_en is registered alongside the state so it tracks RUN/STEP exactly.
  always_comb begin
    state_d  = state_q;
    cpu_en_d = 1'b0;
    case (state_q)
      ST_HALT: begin
        if (succ_s) begin
          state_d = ST_RUN;
        end else if (step_p) begin
          state_d = ST_STEP;
        end else begin
          state_d = ST_HALT;
        end
      end
      ST_RUN: begin
        if (!succ_s) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_STEP: state_d = ST_HALT;
      default: state_d = ST_HALT;
    endcase
    cpu_en_d = (state_d == ST_RUN) || (state_d == ST_STEP);
  end

  // State register, registered enable and executed-cycle counter.
  logic [15:0] cycles_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_HALT;
      cpu_en_q <= 1'b0;
      cycles_q <= 16'd0;
    end else begin
      state_q  <= state_d;
      cpu_en_q <= cpu_en_d;
      cycles_q <= cycles_q + {15'd0, cpu_en_q};
    end
  end

  // ---------------- inspection address ----------------
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              m_rf_prev_q;
  logic              m_rf_chg_s;

  assign m_rf_chg_s = m_rf_s ^ m_rf_prev_q;

  // Target switch change clears the address; otherwise inc/dec step it, cancelling when coincident.
  always_comb begin
    addr_d = addr_q;
    if (m_rf_chg_s) begin
      addr_d = '0;
    end else if (inc_p && !dec_p) begin
      addr_d = addr_q + ADDR_W'(1);
    end else if (dec_p && !inc_p) begin
      addr_d = addr_q - ADDR_W'(1);
    end else begin
      addr_d = addr_q;
    end
  end

  // Address register and previous target level for change detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q      <= '0;
      m_rf_prev_q <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      m_rf_prev_q <= m_rf_s;
    end
  end

  // ---------------- display scanner ----------------
  logic [SCAN_W-1:0] div_q, div_d;
  logic [2:0]        idx_q, idx_d;
  logic              started_q;
  logic [31:0]       snap_q, snap_d;
  logic [7:0]        an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic              tick_s;

  assign tick_s = (div_q == SCAN_LAST);

  // Divider, digit index and frame snapshot; the first tick shows digit 0 of a fresh snapshot.
  always_comb begin
    div_d  = div_q + SCAN_W'(1);
    idx_d  = idx_q;
    snap_d = snap_q;
    an_d   = an_q;
    seg_d  = seg_q;
    if (tick_s) begin
      div_d = '0;
      if (!started_q) begin
        idx_d = 3'd0;
      end else begin
        idx_d = idx_q + 3'd1;
      end
      if (!started_q || (idx_q == 3'd7)) begin
        snap_d = cpu_data;
      end else begin
        snap_d = snap_q;
      end
      an_d  = ~(8'd1 << idx_d);
      seg_d = hex_glyph(snap_d[{idx_d, 2'b00} +: 4]);
    end else begin
      div_d = div_q + SCAN_W'(1);
    end
  end

  // Scanner registers; anodes and segments update on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q     <= '0;
      idx_q     <= 3'd0;
      started_q <= 1'b0;
      snap_q    <= 32'd0;
      an_q      <= 8'hFF;
      seg_q     <= 7'h7F;
    end else begin
      div_q     <= div_d;
      idx_q     <= idx_d;
      started_q <= started_q | tick_s;
      snap_q    <= snap_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
    end
  end

  assign cpu_en    = cpu_en_q;
  assign m_rf_addr = addr_q;
  assign cycles    = cycles_q;
  assign an        = an_q;
  assign seg       = seg_q;

endmodule

// File: tb/tb_dbu_run_ctrl.sv
// Directed bench for dbu_run_ctrl with hand-computed expected values.
module tb_dbu_run_ctrl;

  logic        clk;
  logic        rst;
  logic        succ, step, inc, dec, m_rf;
  logic [31:0] cpu_data;
  logic        cpu_en;
  logic [7:0]  m_rf_addr;
  logic [15:0] cycles;
  logic [7:0]  an;
  logic [6:0]  seg;

  int n_vec;
  int n_err;

  dbu_run_ctrl #(.DEB_CYCLES(4), .SCAN_DIV(16), .ADDR_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .succ      (succ),
    .step      (step),
    .inc       (inc),
    .dec       (dec),
    .m_rf      (m_rf),
    .cpu_data  (cpu_data),
    .cpu_en    (cpu_en),
    .m_rf_addr (m_rf_addr),
    .cycles    (cycles),
    .an        (an),
    .seg       (seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // which: 0 step, 1 inc, 2 dec, 3 inc+dec together. Pattern LSB first, then zeros.
  task automatic run_btn(input int which, input logic [31:0] pat, input int len,
                         input int tail, output int n_en);
    logic b;
    n_en = 0;
    for (int i = 0; i < len + tail; i++) begin
      b = (i < len) ? pat[i] : 1'b0;
      step = (which == 0) ? b : 1'b0;
      inc  = (which == 1 || which == 3) ? b : 1'b0;
      dec  = (which == 2 || which == 3) ? b : 1'b0;
      tick();
      n_en += int'(cpu_en);
    end
    step = 1'b0;
    inc  = 1'b0;
    dec  = 1'b0;
  endtask

  logic [6:0] exp_seg1 [8];
  int         n_en;

  initial begin
    n_vec = 0;
    n_err = 0;
    exp_seg1[0] = 7'h21; exp_seg1[1] = 7'h46; exp_seg1[2] = 7'h03; exp_seg1[3] = 7'h08;
    exp_seg1[4] = 7'h19; exp_seg1[5] = 7'h30; exp_seg1[6] = 7'h24; exp_seg1[7] = 7'h79;

    rst = 1'b0;
    succ = 1'b0; step = 1'b0; inc = 1'b0; dec = 1'b0; m_rf = 1'b0;
    cpu_data = 32'h1234ABCD;
    repeat (3) tick();
    chk("rst_en",     {31'd0, cpu_en}, 32'd0);
    chk("rst_addr",   {24'd0, m_rf_addr}, 32'd0);
    chk("rst_cycles", {16'd0, cycles}, 32'd0);
    chk("rst_an",     {24'd0, an}, 32'hFF);
    chk("rst_seg",    {25'd0, seg}, 32'h7F);

    // release reset; first scan tick lands on the 16th edge
    rst = 1'b1;
    repeat (15) tick();
    chk("an_pre_tick", {24'd0, an}, 32'hFF);
    chk("en_idle",     {31'd0, cpu_en}, 32'd0);
    tick();

    // frame 1: D,C,B,A,4,3,2,1; data changes mid-frame and must not tear it
    for (int d = 0; d < 8; d++) begin
      chk($sformatf("an_d%0d", d),  {24'd0, an},  {24'd0, ~(8'd1 << d)});
      chk($sformatf("seg_d%0d", d), {25'd0, seg}, {25'd0, exp_seg1[d]});
      if (d == 3) cpu_data = 32'h98765430;
      repeat (15) tick();
      chk($sformatf("an_hold_d%0d", d), {24'd0, an}, {24'd0, ~(8'd1 << d)});
      tick();
    end
    chk("f2_an0",  {24'd0, an},  32'hFE);
    chk("f2_seg0", {25'd0, seg}, 32'h40);
    repeat (16) tick();
    chk("f2_an1",  {24'd0, an},  32'hFD);
    chk("f2_seg1", {25'd0, seg}, 32'h30);

    // continuous run for 100 cycles
    succ = 1'b1;
    repeat (2) tick();
    chk("run_en_e2", {31'd0, cpu_en}, 32'd0);
    tick();
    chk("run_en_e3", {31'd0, cpu_en}, 32'd1);
    repeat (97) tick();
    succ = 1'b0;
    repeat (2) tick();
    chk("run_en_e102", {31'd0, cpu_en}, 32'd1);
    tick();
    chk("run_en_e103", {31'd0, cpu_en}, 32'd0);
    chk("run_cycles",  {16'd0, cycles}, 32'd100);

    // single steps: clean, glitch-only, bouncy
    run_btn(0, 32'h000003FF, 10, 30, n_en);
    chk("step_clean_en", n_en, 32'd1);
    chk("step_clean_cyc", {16'd0, cycles}, 32'd101);
    run_btn(0, 32'h00000049, 7, 20, n_en);
    chk("step_glitch_en", n_en, 32'd0);
    chk("step_glitch_cyc", {16'd0, cycles}, 32'd101);
    run_btn(0, 32'h0000BFF5, 16, 30, n_en);
    chk("step_bounce_en", n_en, 32'd1);
    chk("step_bounce_cyc", {16'd0, cycles}, 32'd102);

    // address counter
    run_btn(2, 32'h000000FF, 8, 20, n_en);
    chk("addr_dec_wrap", {24'd0, m_rf_addr}, 32'hFF);
    for (int k = 0; k < 3; k++) run_btn(1, 32'h000000FF, 8, 20, n_en);
    chk("addr_inc3", {24'd0, m_rf_addr}, 32'h02);
    run_btn(3, 32'h000000FF, 8, 20, n_en);
    chk("addr_both", {24'd0, m_rf_addr}, 32'h02);
    m_rf = 1'b1;
    repeat (4) tick();
    chk("addr_mrf_clr", {24'd0, m_rf_addr}, 32'h00);
    run_btn(1, 32'h000000FF, 8, 20, n_en);
    chk("addr_inc1", {24'd0, m_rf_addr}, 32'h01);

    // asynchronous reset while running
    succ = 1'b1;
    repeat (8) tick();
    chk("pre_rst_en", {31'd0, cpu_en}, 32'd1);
    #3;
    rst = 1'b0;
    #1;
    chk("async_en",     {31'd0, cpu_en}, 32'd0);
    chk("async_addr",   {24'd0, m_rf_addr}, 32'd0);
    chk("async_cycles", {16'd0, cycles}, 32'd0);
    chk("async_an",     {24'd0, an}, 32'hFF);
    chk("async_seg",    {25'd0, seg}, 32'h7F);
    tick();
    succ = 1'b0;
    rst = 1'b1;
    tick();
    chk("post_rst_en", {31'd0, cpu_en}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
